// File: rtl/manchester_frame_rx.sv
// Frame deframer behind the Manchester decoder: sync hunt, length/payload/checksum parse, store-and-forward drain.
// Optional MFRX_STATS_EN adds saturating frame ok/error counters (stat_ok_o, stat_err_o).
module manchester_frame_rx #(
    parameter logic [7:0]  SYNC_BYTE    = 8'hD5,
    parameter int unsigned MAX_LEN      = 16,
    parameter int unsigned IDLE_TIMEOUT = 4096
) (
    input  logic        clk16x,
    input  logic        reset,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    input  logic        rx_err_i,
    output logic [7:0]  out_data_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        out_last_o,
    output logic        frame_ok_o,
    output logic        frame_err_o,
    output logic [2:0]  err_code_o
`ifdef MFRX_STATS_EN
    ,
    output logic [15:0] stat_ok_o,
    output logic [15:0] stat_err_o
`endif
);
    localparam int unsigned IW    = $clog2(MAX_LEN + 1);
    localparam int unsigned AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned TW    = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [TW-1:0] IDLE_LAST = TW'(IDLE_TIMEOUT - 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [2:0] ERR_LEN     = 3'd1;
    localparam logic [2:0] ERR_CSUM    = 3'd2;
    localparam logic [2:0] ERR_LINE    = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;
    localparam logic [2:0] ERR_OVERRUN = 3'd5;

    typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CSUM, S_DRAIN} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] last_q, last_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] rd_q, rd_d;
    logic [7:0]    sum_q, sum_d;
    logic [TW-1:0] idle_q, idle_d;
    logic [7:0]    mem_q [DEPTH];

    logic [7:0] out_data_d;
    logic       out_valid_d, out_last_d, frame_ok_d, frame_err_d, wr_en;
    logic [2:0] err_code_d;

    logic in_frame, take, line_err, timeout, len_bad, csum_ok, hs;

    // Error beats a coincident byte; a coincident byte beats the timeout.
    assign in_frame = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CSUM);
    assign take     = rx_valid_i && !rx_err_i;
    assign line_err = in_frame && rx_err_i;
    assign timeout  = in_frame && !rx_valid_i && !rx_err_i && (idle_q == IDLE_LAST);
    assign len_bad  = (rx_data_i == 8'h00) || (rx_data_i > MAX_LEN_B);
    assign csum_ok  = 8'(sum_q + rx_data_i) == 8'h00;
    assign hs       = out_valid_o && out_ready_i;

    always_ff @(posedge clk16x) begin
        if (reset) state_q <= S_HUNT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_HUNT:    if (rx_valid_i && rx_data_i == SYNC_BYTE) state_d = S_LEN;
            S_LEN:     if (line_err || timeout) state_d = S_HUNT;
                       else if (take) state_d = len_bad ? S_HUNT : S_PAYLOAD;
            S_PAYLOAD: if (line_err || timeout) state_d = S_HUNT;
                       else if (take && idx_q == last_q) state_d = S_CSUM;
            S_CSUM:    if (line_err || timeout) state_d = S_HUNT;
                       else if (take) state_d = csum_ok ? S_DRAIN : S_HUNT;
            S_DRAIN:   if (hs && rd_q == last_q) state_d = S_HUNT;
            default:   state_d = S_HUNT;
        endcase
    end

    always_comb begin
        last_d      = last_q;
        idx_d       = idx_q;
        rd_d        = rd_q;
        sum_d       = sum_q;
        idle_d      = '0;
        wr_en       = 1'b0;
        out_data_d  = out_data_o;
        out_valid_d = out_valid_o;
        out_last_d  = out_last_o;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_o;

        if (in_frame && !rx_valid_i) idle_d = idle_q + TW'(1);

        if (line_err) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LINE;
        end else if (timeout) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
        end else begin
            unique case (state_q)
                S_LEN: if (take) begin
                    last_d = IW'(rx_data_i - 8'd1);
                    sum_d  = rx_data_i;
                    idx_d  = '0;
                    if (len_bad) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_LEN;
                    end
                end
                S_PAYLOAD: if (take) begin
                    wr_en = 1'b1;
                    sum_d = 8'(sum_q + rx_data_i);
                    idx_d = idx_q + IW'(1);
                end
                S_CSUM: if (take) begin
                    if (csum_ok) begin
                        frame_ok_d  = 1'b1;
                        out_valid_d = 1'b1;
                        out_data_d  = mem_q[0];
                        out_last_d  = (last_q == '0);
                        rd_d        = '0;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CSUM;
                    end
                end
                S_DRAIN: begin
                    if (rx_valid_i) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_OVERRUN;
                    end
                    if (hs) begin
                        if (rd_q == last_q) begin
                            out_valid_d = 1'b0;
                            out_last_d  = 1'b0;
                        end else begin
                            rd_d       = rd_q + IW'(1);
                            out_data_d = mem_q[AW'(rd_q + IW'(1))];
                            out_last_d = ((rd_q + IW'(1)) == last_q);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk16x) begin
        if (reset) begin
            last_q      <= '0;
            idx_q       <= '0;
            rd_q        <= '0;
            sum_q       <= '0;
            idle_q      <= '0;
            out_data_o  <= '0;
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
            frame_ok_o  <= 1'b0;
            frame_err_o <= 1'b0;
            err_code_o  <= '0;
        end else begin
            last_q      <= last_d;
            idx_q       <= idx_d;
            rd_q        <= rd_d;
            sum_q       <= sum_d;
            idle_q      <= idle_d;
            out_data_o  <= out_data_d;
            out_valid_o <= out_valid_d;
            out_last_o  <= out_last_d;
            frame_ok_o  <= frame_ok_d;
            frame_err_o <= frame_err_d;
            err_code_o  <= err_code_d;
        end
    end

    // Payload buffer holds no control state, so it is left out of reset.
    always_ff @(posedge clk16x) begin
        if (wr_en) mem_q[AW'(idx_q)] <= rx_data_i;
    end

`ifdef MFRX_STATS_EN
    always_ff @(posedge clk16x) begin
        if (reset) begin
            stat_ok_o  <= '0;
            stat_err_o <= '0;
        end else begin
            if (frame_ok_d && stat_ok_o != 16'hFFFF)   stat_ok_o  <= stat_ok_o + 16'd1;
            if (frame_err_d && stat_err_o != 16'hFFFF) stat_err_o <= stat_err_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_manchester_frame_rx.sv
// Directed self-checking bench for manchester_frame_rx (IDLE_TIMEOUT=16, MAX_LEN=16).
module tb_manchester_frame_rx;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_err = 1'b0;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic        out_valid, out_last, frame_ok, frame_err;
    logic [2:0]  err_code;
`ifdef MFRX_STATS_EN
    logic [15:0] stat_ok, stat_err;
`endif

    manchester_frame_rx #(
        .SYNC_BYTE(8'hD5), .MAX_LEN(16), .IDLE_TIMEOUT(16)
    ) dut (
        .clk16x(clk), .reset(reset),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_err_i(rx_err),
        .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_last_o(out_last), .frame_ok_o(frame_ok), .frame_err_o(frame_err),
        .err_code_o(err_code)
`ifdef MFRX_STATS_EN
        , .stat_ok_o(stat_ok), .stat_err_o(stat_err)
`endif
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int ok_cnt = 0;
    int err_cnt = 0;
    int out_n = 0;
    logic [8:0] out_log [256];
    logic [8:0] exp_pl [3] = '{9'h011, 9'h022, 9'h133};

    // Pulse counters and a log of every accepted output beat {last, data}.
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_ok)  ok_cnt <= ok_cnt + 1;
            if (frame_err) err_cnt <= err_cnt + 1;
            if (out_valid && out_ready) begin
                out_log[out_n[7:0]] <= {out_last, out_data};
                out_n <= out_n + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_good();
        send(8'hD5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h97);
    endtask

    task automatic check_payload(input string tag, input int base);
        check({tag, "_count"}, 32'(out_n - base), 32'd3);
        for (int i = 0; i < 3; i++)
            check({tag, "_beat"}, 32'(out_log[8'(base + i)]), 32'(exp_pl[i]));
    endtask

    initial begin
        int base, e0, o0, hit;
        logic stable;

        tick(); tick();
        check("rst_outputs", {out_data, out_valid, out_last, frame_ok, frame_err, err_code}, 32'h0);
        reset = 1'b0;
        tick();

        // Good frame with preamble.
        base = out_n;
        send(8'h55); send(8'h55); send_good();
        check("good_ok_pulse", {frame_ok, out_valid, out_data, out_last}, {1'b1, 1'b1, 8'h11, 1'b0});
        tick();
        check("good_ok_once", frame_ok, 1'b0);
        tick(); tick(); tick();
        check("good_valid_low", out_valid, 1'b0);
        check_payload("good", base);
        check("good_counts", {ok_cnt[7:0], err_cnt[7:0], 5'd0, err_code}, {8'd1, 8'd0, 8'd0});

        // Bad checksum then a good frame.
        base = out_n;
        send(8'hD5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h98);
        check("csum_err", {frame_err, err_code, out_valid}, {1'b1, 3'd2, 1'b0});
        tick(); tick();
        check("csum_no_out", 32'(out_n - base), 32'd0);
        base = out_n;
        send_good();
        tick(); tick(); tick(); tick();
        check_payload("after_csum", base);

        // Zero and oversize lengths.
        e0 = err_cnt;
        send(8'hD5); send(8'h00);
        check("len0", {frame_err, err_code}, {1'b1, 3'd1});
        tick();
        send(8'hD5); send(8'h11);
        check("len17", {frame_err, err_code}, {1'b1, 3'd1});
        tick();
        check("len_pulses", 32'(err_cnt - e0), 32'd2);

        // Backpressure with an overrun byte mid-stall.
        out_ready = 1'b0;
        base = out_n;
        send_good();
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin rx_data = 8'hD5; rx_valid = 1'b1; end
            tick();
            rx_valid = 1'b0;
            if (i == 2) check("overrun", {frame_err, err_code}, {1'b1, 3'd5});
            stable &= (out_valid && out_data == 8'h11 && !out_last);
        end
        check("bp_stable", stable, 1'b1);
        out_ready = 1'b1;
        tick(); tick(); tick(); tick();
        check_payload("bp", base);
        check("bp_done", out_valid, 1'b0);

        // Line error mid-payload.
        send(8'hD5); send(8'h03); send(8'h11);
        rx_err = 1'b1; tick(); rx_err = 1'b0;
        check("line_err", {frame_err, err_code}, {1'b1, 3'd3});
        tick();

        // Silence after a payload byte.
        send(8'hD5); send(8'h03); send(8'h11);
        hit = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (frame_err && hit == 0) hit = i;
        end
        check("timeout_cycle", 32'(hit), 32'd16);
        check("timeout_code", err_code, 3'd4);

        // Byte arriving on the would-be timeout cycle keeps the frame alive.
        e0 = err_cnt;
        base = out_n;
        send(8'hD5); send(8'h03); send(8'h11);
        repeat (15) tick();
        send(8'h22);
        check("tmo_byte_wins", frame_err, 1'b0);
        send(8'h33); send(8'h97);
        check("tmo_frame_ok", frame_ok, 1'b1);
        tick(); tick(); tick(); tick();
        check("tmo_no_err", 32'(err_cnt - e0), 32'd0);
        check_payload("tmo", base);

        // Error with a coincident SYNC byte: dropped and not rechecked.
        send(8'hD5); send(8'h03); send(8'h11);
        rx_data = 8'hD5; rx_valid = 1'b1; rx_err = 1'b1;
        tick();
        rx_valid = 1'b0; rx_err = 1'b0;
        check("coinc_err", {frame_err, err_code}, {1'b1, 3'd3});
        o0 = ok_cnt;
        send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h97);
        tick(); tick(); tick(); tick();
        check("coinc_no_frame", {32'(ok_cnt - o0)}, 32'd0);
        check("coinc_no_valid", out_valid, 1'b0);

        // Reset mid-payload.
        send(8'hD5); send(8'h03); send(8'h11);
        e0 = err_cnt;
        reset = 1'b1;
        tick();
        check("midrst_outputs", {out_data, out_valid, out_last, frame_ok, frame_err, err_code}, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        base = out_n;
        send_good();
        check("midrst_ok", frame_ok, 1'b1);
        tick(); tick(); tick(); tick();
        check_payload("midrst", base);
        check("midrst_no_err", 32'(err_cnt - e0), 32'd0);
`ifdef MFRX_STATS_EN
        check("stats", {stat_ok, stat_err}, {16'd1, 16'd0});
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
